apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Initiator end of the APB_BUS protocol: converts the core-style request/grant/rvalid data port into single APB3 master transfers driven onto an APB_BUS.Master port.
- Sits between the AXI/core-side peripheral path and the SoC APB interconnect that decodes UART, GPIO, SPI, TIMER and other windows.
- Exactly one outstanding transfer; every access costs at least one SETUP and one ACCESS phase.

Parameters:
- APB_ADDR_WIDTH, 32, paddr width.
- APB_DATA_WIDTH, 32, pwdata/prdata width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort. Used only when APB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req_i  in  1  transfer request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  APB_ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- wdata_i  in  APB_DATA_WIDTH  write data.
- rvalid_o  out  1  one-cycle completion pulse, for both reads and writes.
- rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o.
- err_o  out  1  error flag, valid with rvalid_o.
- apb_master  APB_BUS.Master  -  paddr/pwdata/pwrite/psel/penable out; prdata/pready/pslverr in.

Behaviour:
- Reset:
  - Clock is clk; reset is rst, asynchronous and active-high.
  - All outputs go to 0 immediately: gnt_o, rvalid_o, rdata_o, err_o, paddr, pwdata, pwrite, psel, penable. State goes to IDLE.
  - Reset mid-transfer aborts the transfer: psel/penable drop asynchronously and no rvalid_o is ever produced for the aborted request.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i, combinational.
  - On req_i & gnt_o: register addr_i with bits [1:0] forced to 0, we_i and wdata_i; go to SETUP.
- SETUP: psel=1, penable=0; go to ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1.
  - If pready=1: capture prdata (reads only; writes capture 0) and pslverr; go to RESP.
  - Otherwise stay in ACCESS.
- RESP:
  - psel=0, penable=0, rvalid_o=1, rdata_o and err_o hold the captured values; go to IDLE.
  - rdata_o and err_o return to 0 in the following cycle.
- gnt_o=0 in SETUP, ACCESS and RESP. A request held during RESP is granted in the next IDLE cycle.
- Minimum latency: grant at cycle N, SETUP at N+1, ACCESS at N+2 (pready=1), rvalid_o at N+3. Back-to-back throughput is one transfer per 4 cycles.
- Address and data stability:
  - paddr, pwrite and pwdata are registered and stay stable from SETUP through the final ACCESS cycle.
  - They hold their last value in IDLE and RESP and never toggle without a new grant.
- Full-word transfers only; there is no byte-enable path.
- pslverr is sampled only on the ACCESS cycle where pready=1 and is ignored otherwise.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width $clog2(TIMEOUT_CYCLES) clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - If the count reaches TIMEOUT_CYCLES-1 with pready still 0, that cycle is the last ACCESS cycle. The next cycle is RESP with psel=0, rdata_o=0, err_o=1.
  - If pready arrives on the same cycle as the timeout, pready wins and the normal response is returned.
- Undefined: ACCESS waits indefinitely, no counter logic is generated, and TIMEOUT_CYCLES is unused.

Decomposition:
- apb_bridge_pkg holds:
  - the state enum apb_state_e (IDLE, SETUP, ACCESS, RESP);
  - the localparam APB_TIMEOUT_DEFAULT = 256.
- Sub-module apb_bridge_wdog (counter plus expire flag) is instantiated only under APB_TIMEOUT_EN. The FSM and datapath stay in apb_master_bridge.

Test Plan:
- Read, pready=1 immediately, addr_i=0x1A10_1004, prdata=0xCAFE_0001 -> psel high cycles N+1..N+2, penable at N+2, rvalid_o at N+3 with rdata_o=0xCAFE_0001, err_o=0.
- Write, addr_i=0x1A10_3002, wdata_i=0x0000_00FF, pready delayed 3 cycles -> paddr=0x1A10_3000, pwrite=1, pwdata=0x0000_00FF stable for 4 ACCESS cycles; rvalid_o with rdata_o=0.
- Read with pslverr=1 on the pready cycle -> rvalid_o with err_o=1; a pslverr pulse on a non-pready cycle is ignored.
- req_i held high for 3 back-to-back reads -> grants at cycles 0, 4, 8; exactly 3 rvalid_o pulses; gnt_o=0 in between.
- Assert rst during ACCESS -> psel/penable=0 in the same cycle, no rvalid_o; the next request after reset completes normally.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and pready stuck at 0 -> 8 ACCESS cycles, then RESP with err_o=1, rdata_o=0; pready arriving at the 8th cycle returns normal data instead.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the APB master bridge.
// APB_TIMEOUT_EN (see apb_master_bridge) enables the ACCESS-phase watchdog.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int APB_TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle shared by the bridge (Master) and the interconnect or
// peripheral models (Slave).
interface APB_BUS #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_bridge_wdog.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the last one.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_bridge_wdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);
    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count) begin
            r_count <= r_count + 1'b1;
        end
    end

    // i_count already excludes pready, so a same-cycle pready is never expired
    assign o_expired = i_count && (r_count == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid port to single APB3 master transfers, one outstanding.
// Define APB_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYCLES cycles.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    APB_BUS.Master                    apb_master
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 2");
    end

    apb_state_e                r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [APB_DATA_WIDTH-1:0] r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_rvalid;
    logic [APB_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic                      w_expired;
    logic                      w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^addr_i[1:0];

`ifdef APB_TIMEOUT_EN
    apb_bridge_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == SETUP),
        .i_count   ((r_state == ACCESS) && !apb_master.pready),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Gated by rst so the grant is low while reset is held
    assign gnt_o = req_i && (r_state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pwrite  <= 1'b0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_paddr  <= {addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                        r_pwrite <= we_i;
                        r_pwdata <= wdata_i;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (apb_master.pready) begin
                        r_rdata   <= r_pwrite ? '0 : apb_master.prdata;
                        r_err     <= apb_master.pslverr;
                        r_rvalid  <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= RESP;
                    end else if (w_expired) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_rvalid  <= 1'b1;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                    r_err    <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rvalid_o           = r_rvalid;
    assign rdata_o            = r_rdata;
    assign err_o              = r_err;
    assign apb_master.paddr   = r_paddr;
    assign apb_master.pwdata  = r_pwdata;
    assign apb_master.pwrite  = r_pwrite;
    assign apb_master.psel    = r_psel;
    assign apb_master.penable = r_penable;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, random transfers
// against a transfer-level model, and hand-written multi-cycle sequences.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          delay;
        logic        slverr;
        logic        glitch;
        logic [31:0] expPaddr;
        logic [31:0] expRdata;
        logic        expErr;
        int          expAccess;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqI;
    logic        gntO;
    logic [31:0] addrI;
    logic        weI;
    logic [31:0] wdataI;
    logic        rvalidO;
    logic [31:0] rdataO;
    logic        errO;

    int checks = 0;
    int errors = 0;

    APB_BUS #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apbBus ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (reqI),
        .gnt_o      (gntO),
        .addr_i     (addrI),
        .we_i       (weI),
        .wdata_i    (wdataI),
        .rvalid_o   (rvalidO),
        .rdata_o    (rdataO),
        .err_o      (errO),
        .apb_master (apbBus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transfer-level model: aligned address, write returns 0, watchdog aborts
    function automatic vec_t modelTxn(input vec_t v);
        vec_t r = v;
        r.expPaddr  = v.addr & 32'hFFFF_FFFC;
        r.expRdata  = v.we ? 32'h0 : v.prdata;
        r.expErr    = v.slverr;
        r.expAccess = v.delay + 1;
`ifdef APB_TIMEOUT_EN
        if (v.delay >= TO) begin
            r.expAccess = TO;
            r.expRdata  = 32'h0;
            r.expErr    = 1'b1;
        end
`endif
        return r;
    endfunction

    // Runs one transfer starting just after a negedge with the DUT idle
    task automatic applyStimulus(input vec_t v, input string tag);
        reqI   = 1'b1;
        weI    = v.we;
        addrI  = v.addr;
        wdataI = v.wdata;
        apbBus.prdata  = v.prdata;
        apbBus.pready  = 1'b0;
        apbBus.pslverr = 1'b0;
        #1;
        checkOutput({tag, ".gnt"}, 32'(gntO), 32'd1);
        @(negedge clk);
        reqI   = 1'b0;
        weI    = ~v.we;
        addrI  = ~v.addr;
        wdataI = ~v.wdata;
        #1;
        checkOutput({tag, ".setup.psel"}, 32'(apbBus.psel), 32'd1);
        checkOutput({tag, ".setup.penable"}, 32'(apbBus.penable), 32'd0);
        checkOutput({tag, ".setup.paddr"}, apbBus.paddr, v.expPaddr);
        checkOutput({tag, ".setup.pwrite"}, 32'(apbBus.pwrite), 32'(v.we));
        checkOutput({tag, ".setup.pwdata"}, apbBus.pwdata, v.wdata);
        checkOutput({tag, ".setup.gnt"}, 32'(gntO), 32'd0);
        for (int k = 0; k < v.expAccess; k++) begin
            @(negedge clk);
            apbBus.pready  = (k == v.delay);
            apbBus.pslverr = (k == v.delay) ? v.slverr : v.glitch;
            #1;
            checkOutput($sformatf("%s.acc%0d.psel", tag, k), 32'(apbBus.psel), 32'd1);
            checkOutput($sformatf("%s.acc%0d.penable", tag, k), 32'(apbBus.penable), 32'd1);
            checkOutput($sformatf("%s.acc%0d.paddr", tag, k), apbBus.paddr, v.expPaddr);
            checkOutput($sformatf("%s.acc%0d.pwdata", tag, k), apbBus.pwdata, v.wdata);
            checkOutput($sformatf("%s.acc%0d.rvalid", tag, k), 32'(rvalidO), 32'd0);
        end
        @(negedge clk);
        apbBus.pready  = 1'b0;
        apbBus.pslverr = 1'b0;
        #1;
        checkOutput({tag, ".resp.rvalid"}, 32'(rvalidO), 32'd1);
        checkOutput({tag, ".resp.rdata"}, rdataO, v.expRdata);
        checkOutput({tag, ".resp.err"}, 32'(errO), 32'(v.expErr));
        checkOutput({tag, ".resp.psel"}, 32'(apbBus.psel), 32'd0);
        checkOutput({tag, ".resp.penable"}, 32'(apbBus.penable), 32'd0);
        checkOutput({tag, ".resp.paddr"}, apbBus.paddr, v.expPaddr);
        @(negedge clk);
        #1;
        checkOutput({tag, ".idle.rvalid"}, 32'(rvalidO), 32'd0);
        checkOutput({tag, ".idle.rdata"}, rdataO, 32'd0);
        checkOutput({tag, ".idle.err"}, 32'(errO), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global.timeout: got hang expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        vec_t vecs[4];
        vec_t v;
        int   rvCount;

        vecs[0] = '{1'b0, 32'h1A10_1004, 32'h0,         32'hCAFE_0001, 0, 1'b0, 1'b0,
                    32'h1A10_1004, 32'hCAFE_0001, 1'b0, 1};
        vecs[1] = '{1'b1, 32'h1A10_3002, 32'h0000_00FF, 32'hDEAD_BEEF, 3, 1'b0, 1'b0,
                    32'h1A10_3000, 32'h0,         1'b0, 4};
        vecs[2] = '{1'b0, 32'h1A10_2008, 32'h0,         32'h1234_5678, 2, 1'b1, 1'b0,
                    32'h1A10_2008, 32'h1234_5678, 1'b1, 3};
        vecs[3] = '{1'b0, 32'h1A10_400F, 32'h0,         32'h5555_AAAA, 2, 1'b0, 1'b1,
                    32'h1A10_400C, 32'h5555_AAAA, 1'b0, 3};

        rst    = 1'b1;
        reqI   = 1'b1;
        weI    = 1'b0;
        addrI  = 32'hFFFF_FFFF;
        wdataI = 32'hFFFF_FFFF;
        apbBus.prdata  = 32'h0;
        apbBus.pready  = 1'b0;
        apbBus.pslverr = 1'b0;
        #2;
        checkOutput("reset.gnt", 32'(gntO), 32'd0);
        checkOutput("reset.rvalid", 32'(rvalidO), 32'd0);
        checkOutput("reset.rdata", rdataO, 32'd0);
        checkOutput("reset.err", 32'(errO), 32'd0);
        checkOutput("reset.psel", 32'(apbBus.psel), 32'd0);
        checkOutput("reset.penable", 32'(apbBus.penable), 32'd0);
        checkOutput("reset.paddr", apbBus.paddr, 32'd0);
        checkOutput("reset.pwdata", apbBus.pwdata, 32'd0);
        checkOutput("reset.pwrite", 32'(apbBus.pwrite), 32'd0);
        @(negedge clk);
        reqI = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 12; i++) begin
            v.we     = 1'($urandom_range(0, 1));
            v.addr   = $urandom();
            v.wdata  = $urandom();
            v.prdata = $urandom();
            v.delay  = $urandom_range(0, 5);
            v.slverr = 1'($urandom_range(0, 1));
            v.glitch = 1'($urandom_range(0, 1));
            applyStimulus(modelTxn(v), $sformatf("rand%0d", i));
        end

        // Held request: grants every fourth cycle, completions one cycle before
        rvCount = 0;
        reqI   = 1'b1;
        weI    = 1'b0;
        addrI  = 32'h1A10_5000;
        apbBus.prdata = 32'hB0B0_0003;
        apbBus.pready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("b2b.c%0d.gnt", c), 32'(gntO), 32'((c % 4) == 0));
            checkOutput($sformatf("b2b.c%0d.rvalid", c), 32'(rvalidO), 32'((c % 4) == 3));
            if (rvalidO) begin
                rvCount++;
                checkOutput($sformatf("b2b.c%0d.rdata", c), rdataO, 32'hB0B0_0003);
            end
            if (c == 11) reqI = 1'b0;
            @(negedge clk);
            #1;
        end
        checkOutput("b2b.count", 32'(rvCount), 32'd3);
        apbBus.pready = 1'b0;

        // Reset asserted mid-ACCESS
        reqI   = 1'b1;
        addrI  = 32'h1A10_6000;
        #1;
        checkOutput("rstmid.gnt", 32'(gntO), 32'd1);
        @(negedge clk);
        reqI = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstmid.acc.penable", 32'(apbBus.penable), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid.psel", 32'(apbBus.psel), 32'd0);
        checkOutput("rstmid.penable", 32'(apbBus.penable), 32'd0);
        checkOutput("rstmid.rvalid", 32'(rvalidO), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apbBus.pready = 1'b1;
        rvCount = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (rvalidO) rvCount++;
        end
        checkOutput("rstmid.noresp", 32'(rvCount), 32'd0);
        apbBus.pready = 1'b0;
        v = '{1'b0, 32'h1A10_6004, 32'h0, 32'h7777_0001, 1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0};
        applyStimulus(modelTxn(v), "postrst");

`ifdef APB_TIMEOUT_EN
        v = '{1'b0, 32'h1A10_7000, 32'h0, 32'h9999_0001, 50, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0};
        applyStimulus(modelTxn(v), "tmo.stuck");
        v = '{1'b0, 32'h1A10_7004, 32'h0, 32'h9999_0002, TO - 1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0};
        applyStimulus(modelTxn(v), "tmo.lastready");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
